noc_vc_alloc_sched: RTL
=======================

// Module: noc_vc_alloc_sched
// PURPOSE
// Packet-level virtual-channel allocator/scheduler for a NoC bridge port. Takes one wormhole
// flit stream and, per packet, picks an output VC round-robin among enabled VCs with credit.
// It holds that VC from header to tail, pushes flits out through a one-stage register, and
// tracks per-VC downstream credits. Sits between a local injection source and a router input.
// PARAMETERS
// FLIT_W    32  flit payload width
// NUM_VC    2   number of output virtual channels (>=2)
// VC_DEPTH  4   downstream buffer depth per VC = initial/max credit count
// CNT_W     $clog2(VC_DEPTH+1)  credit counter width (derived, do not override)
// PORTS
// noc_clk        in   1          clock
// noc_rst_n      in   1          reset, asynchronous, active-low
// in_valid       in   1          upstream flit valid
// in_ready       out  1          flit accepted when in_valid&in_ready
// in_flit        in   FLIT_W     upstream flit
// in_is_header   in   1          flit is packet header
// in_is_tail     in   1          flit is packet tail (header&tail = single-flit packet)
// cfg_vc_en      in   NUM_VC     per-VC allocation enable (static config, sampled in IDLE)
// credit_return  in   NUM_VC     1-cycle pulse per freed downstream slot, per VC
// out_valid      out  NUM_VC     one-hot push strobe to selected VC (no ready; credit-based)
// out_flit       out  FLIT_W     registered flit
// out_is_header  out  1          registered header flag
// out_is_tail    out  1          registered tail flag
// vc_credit      out  NUM_VC*CNT_W  current credit count per VC, VC0 in LSBs
// busy           out  1          FSM in ACTIVE (VC held)
// proto_err      out  1          1-cycle pulse: non-header flit dropped in IDLE
// credit_err     out  1          1-cycle pulse: credit_return on a VC already at VC_DEPTH
// BEHAVIOUR
// - Reset: state=IDLE, rr_ptr=0, grant=0, all credits=VC_DEPTH, out_valid=0, out_flit=0,
//   out_is_header=0, out_is_tail=0, busy=0, proto_err=0, credit_err=0. Reset mid-packet aborts it.
// - FSM IDLE: eligible[v] = cfg_vc_en[v] & (credit[v]!=0). If in_valid&in_is_header and any eligible:
//   in_ready=0 this cycle, grant <= first eligible at or after rr_ptr (wrapping), go ACTIVE.
//   If in_valid&!in_is_header: in_ready=1, flit dropped, proto_err pulses next cycle.
//   Header with no eligible VC: in_ready=0, stay IDLE.
// - FSM ACTIVE: in_ready = (credit[grant]!=0); driven from registers only, never from in_valid.
//   On accept: credit[grant]-1; next cycle out_valid=1<<grant with flit/flags (latency 1).
//   Accepted tail: go IDLE, rr_ptr <= (grant+1) mod NUM_VC. Header flag ignored in ACTIVE.
// - Allocation costs 1 bubble: header accepted earliest 1 cycle after first presented.
// - Single-flit packet: accepted in ACTIVE as a tail, returns to IDLE next cycle.
// - out_valid deasserts (0) in any cycle with no accept; out_flit/flags hold last value.
// - Credits: consume and return on same VC in same cycle -> unchanged. Return at VC_DEPTH
//   (no same-cycle consume) -> saturate, credit_err pulses. Counter never underflows.
// - Credit returns are honoured in every state, including IDLE and for non-granted VCs.
// - cfg_vc_en change while ACTIVE does not affect the current packet.
// TESTING (NUM_VC=2, VC_DEPTH=4, cfg_vc_en=2'b11)
// 1 Release reset -> vc_credit={4,4}, in_ready=0, out_valid=0, busy=0, all errs 0.
// 2 3-flit pkt A1..A3 held valid -> 1 bubble, busy=1, out_valid=2'b01 A1,A2,A3 on consecutive
//   cycles after each accept; credit0=1, credit1=4; IDLE after tail; next pkt goes to VC1.
// 3 6-flit pkt on VC0, no returns -> in_ready low after 4 accepts; credit_return=2'b01 pulse
//   -> exactly one more flit accepted; same-cycle consume+return keeps count constant.
// 4 Force credit0=0 (drain), rr_ptr=0 -> header granted VC1; cfg_vc_en=2'b00 -> header stalls,
//   in_ready=0, stays IDLE until enable set.
// 5 Non-header flit in IDLE -> in_ready=1, no out_valid, proto_err=1 for one cycle.
//   credit_return on full VC -> credit_err=1 for one cycle, count stays 4.
// 6 Assert noc_rst_n=0 mid-packet -> outputs/credits at reset values immediately.
//   After release, a fresh header is allocated normally to VC0.

Source files
------------

// File: rtl/noc_vc_alloc_sched.sv
// noc_vc_alloc_sched
// Packet-level virtual-channel allocator/scheduler for a NoC bridge port. Each wormhole packet
// arriving on the single input stream is bound, at its header, to one output VC. The VC is
// chosen round-robin among VCs that are enabled and have downstream credit. The binding holds
// until the tail flit, and flits leave through a one-stage output register. Downstream buffer
// space is tracked with one credit counter per VC.
//
// Ports
//   noc_clk, noc_rst_n  clock, asynchronous active-low reset
//   in_valid/in_ready   upstream flit handshake; in_flit, in_is_header, in_is_tail payload
//   cfg_vc_en           per-VC allocation enable, sampled only when picking a VC
//   credit_return       per-VC pulse, one per freed downstream slot
//   out_valid           one-hot push strobe to the granted VC (credit-based, no ready)
//   out_flit, out_is_header, out_is_tail  registered flit and flags
//   vc_credit           credit count per VC, VC0 in the LSBs
//   busy                a VC is currently held by a packet
//   proto_err           pulse: non-header flit dropped while no packet was open
//   credit_err          pulse: credit returned to a VC that already had full credit
module noc_vc_alloc_sched #(
  parameter int unsigned FLIT_W   = 32,
  parameter int unsigned NUM_VC   = 2,
  parameter int unsigned VC_DEPTH = 4,
  parameter int unsigned CNT_W    = $clog2(VC_DEPTH + 1)
) (
  input  logic                    noc_clk,
  input  logic                    noc_rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FLIT_W-1:0]       in_flit,
  input  logic                    in_is_header,
  input  logic                    in_is_tail,
  input  logic [NUM_VC-1:0]       cfg_vc_en,
  input  logic [NUM_VC-1:0]       credit_return,
  output logic [NUM_VC-1:0]       out_valid,
  output logic [FLIT_W-1:0]       out_flit,
  output logic                    out_is_header,
  output logic                    out_is_tail,
  output logic [NUM_VC*CNT_W-1:0] vc_credit,
  output logic                    busy,
  output logic                    proto_err,
  output logic                    credit_err
);

  localparam int unsigned IdxW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e            r_state, w_state_d;
  logic [IdxW-1:0]   r_grant, w_grant_d;
  logic [IdxW-1:0]   r_rr_ptr, w_rr_d;
  logic [CNT_W-1:0]  r_credit [NUM_VC];
  logic [CNT_W-1:0]  w_credit_d [NUM_VC];
  logic [NUM_VC-1:0] r_out_valid;
  logic [FLIT_W-1:0] r_out_flit;
  logic              r_out_is_header, r_out_is_tail;
  logic              r_proto_err, w_proto_d;
  logic              r_credit_err, w_credit_err_d;

  logic [NUM_VC-1:0] w_eligible;
  logic [IdxW-1:0]   w_pick;
  logic              w_found;
  logic              w_accept;

  always_comb begin
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      w_eligible[v] = cfg_vc_en[v] & (r_credit[v] != '0);
    end
  end

  // First eligible VC at or after the round-robin pointer, wrapping.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    w_pick  = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      idx = (32'(r_rr_ptr) + i) % NUM_VC;
      if (!w_found && w_eligible[idx[IdxW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = idx[IdxW-1:0];
      end
    end
  end

  // Allocation spends one cycle with in_ready low; the header itself is taken in StActive.
  always_comb begin
    w_state_d  = r_state;
    w_grant_d  = r_grant;
    w_rr_d     = r_rr_ptr;
    in_ready   = 1'b0;
    w_accept   = 1'b0;
    w_proto_d  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          if (in_is_header) begin
            if (w_found) begin
              w_grant_d = w_pick;
              w_state_d = StActive;
            end
          end else begin
            in_ready  = 1'b1;
            w_proto_d = 1'b1;
          end
        end
      end
      StActive: begin
        in_ready = (r_credit[r_grant] != '0);
        w_accept = in_valid & in_ready;
        if (w_accept && in_is_tail) begin
          w_state_d = StIdle;
          w_rr_d    = (r_grant == IdxW'(NUM_VC - 1)) ? '0 : r_grant + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // A consume and a return on the same VC in the same cycle cancel out.
  always_comb begin
    logic consume;
    consume        = 1'b0;
    w_credit_err_d = 1'b0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      w_credit_d[v] = r_credit[v];
      consume       = w_accept && (r_grant == IdxW'(v));
      if (consume && !credit_return[v]) begin
        w_credit_d[v] = r_credit[v] - 1'b1;
      end else if (!consume && credit_return[v]) begin
        if (r_credit[v] == CNT_W'(VC_DEPTH)) begin
          w_credit_err_d = 1'b1;
        end else begin
          w_credit_d[v] = r_credit[v] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_state         <= StIdle;
      r_grant         <= '0;
      r_rr_ptr        <= '0;
      r_out_valid     <= '0;
      r_out_flit      <= '0;
      r_out_is_header <= 1'b0;
      r_out_is_tail   <= 1'b0;
      r_proto_err     <= 1'b0;
      r_credit_err    <= 1'b0;
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        r_credit[v] <= CNT_W'(VC_DEPTH);
      end
    end else begin
      r_state      <= w_state_d;
      r_grant      <= w_grant_d;
      r_rr_ptr     <= w_rr_d;
      r_proto_err  <= w_proto_d;
      r_credit_err <= w_credit_err_d;
      r_out_valid  <= w_accept ? (NUM_VC'(1) << r_grant) : '0;
      if (w_accept) begin
        r_out_flit      <= in_flit;
        r_out_is_header <= in_is_header;
        r_out_is_tail   <= in_is_tail;
      end
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        r_credit[v] <= w_credit_d[v];
      end
    end
  end

  always_comb begin
    vc_credit = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      vc_credit[v*CNT_W +: CNT_W] = r_credit[v];
    end
  end

  assign out_valid     = r_out_valid;
  assign out_flit      = r_out_flit;
  assign out_is_header = r_out_is_header;
  assign out_is_tail   = r_out_is_tail;
  assign busy          = (r_state == StActive);
  assign proto_err     = r_proto_err;
  assign credit_err    = r_credit_err;

endmodule
